// File: rtl/bus_memory.sv
// bus_memory: single-port RAM with a request/ready bus, programmable wait states
// and a write-protected top region that flags violating writes.
module bus_memory #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] ROM_BASE    = 'hF000
) (
  input  logic              cpu_clk,
  input  logic              cpu_reset_n,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              mem_oe_i,
  input  logic              mem_we_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_ready_o,
  output logic              mem_busy_o,
  output logic              mem_wp_err_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data, r_rdata;
  logic              r_we, r_wp;
  logic              w_req, w_we, w_wp, w_enter_ack;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  // With no wait states the access completes straight from IDLE, so the
  // live bus values stand in for the captured ones on that edge.
  assign w_req       = mem_oe_i ^ mem_we_i;
  assign w_addr      = r_state == S_IDLE ? mem_addr_i : r_addr;
  assign w_data      = r_state == S_IDLE ? mem_data_i : r_data;
  assign w_we        = r_state == S_IDLE ? mem_we_i : r_we;
  assign w_wp        = w_addr >= ROM_BASE;
  assign w_enter_ack = w_next == S_ACK;

  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE ? (w_req ? (WAIT_STATES > 0 ? S_WAIT : S_ACK) : S_IDLE)
           : r_state == S_WAIT ? (r_cnt == '0 ? S_ACK : S_WAIT)
           : S_IDLE;
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_reset_n) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_reset_n) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_wp    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_addr <= mem_addr_i;
        r_data <= mem_data_i;
        r_we   <= mem_we_i;
        r_cnt  <= CNT_LOAD;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_ack && !w_we) r_rdata <= r_mem[w_addr];
      if (w_enter_ack && w_we && w_wp) r_wp <= 1'b1;
    end
  end

  // Storage is deliberately outside reset; reset only blocks a pending commit.
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset_n && w_enter_ack && w_we && !w_wp) r_mem[w_addr] <= w_data;
  end

  assign mem_data_o   = r_rdata;
  assign mem_ready_o  = r_state == S_ACK;
  assign mem_busy_o   = r_state != S_IDLE;
  assign mem_wp_err_o = r_wp;
endmodule

// File: tb/tb_bus_memory.sv
// tb_bus_memory: drives a zero-wait and a three-wait bus_memory with directed
// and random accesses, checking against an associative-array memory model.
module tb_bus_memory;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       oe [2];
  logic       we [2];
  logic [15:0] addr [2];
  logic [7:0] din [2];
  logic [7:0] dout [2];
  logic       rdy [2];
  logic       busy [2];
  logic       wp [2];

  always #5 clk = ~clk;

  bus_memory #(.WAIT_STATES(0)) u_ws0 (
    .cpu_clk(clk), .cpu_reset_n(rst_n), .mem_addr_i(addr[0]), .mem_oe_i(oe[0]),
    .mem_we_i(we[0]), .mem_data_i(din[0]), .mem_data_o(dout[0]),
    .mem_ready_o(rdy[0]), .mem_busy_o(busy[0]), .mem_wp_err_o(wp[0])
  );

  bus_memory #(.WAIT_STATES(3)) u_ws3 (
    .cpu_clk(clk), .cpu_reset_n(rst_n), .mem_addr_i(addr[1]), .mem_oe_i(oe[1]),
    .mem_we_i(we[1]), .mem_data_i(din[1]), .mem_data_o(dout[1]),
    .mem_ready_o(rdy[1]), .mem_busy_o(busy[1]), .mem_wp_err_o(wp[1])
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] mdl [bit [16:0]];
  logic [7:0] m_dout [2];
  bit         m_dknown [2];
  bit         m_wp [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ws(input int k);
    return k == 0 ? 0 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_dout[k] = 8'h00;
      m_dknown[k] = 1'b1;
      m_wp[k] = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_d%0d_ready", tag, k), rdy[k], 0);
      check($sformatf("%s_d%0d_busy", tag, k), busy[k], 0);
      check($sformatf("%s_d%0d_data", tag, k), dout[k], 0);
      check($sformatf("%s_d%0d_wp", tag, k), wp[k], 0);
    end
  endtask

  task automatic access(input int k, input bit wr, input logic [15:0] a, input logic [7:0] d);
    int n;
    int nb;
    bit [16:0] key;
    key = {k[0], a};
    @(negedge clk);
    addr[k] = a; din[k] = d; oe[k] = !wr; we[k] = wr;
    @(posedge clk); #1;
    oe[k] = 1'b0; we[k] = 1'b0;
    n = 1; nb = 0;
    while (!rdy[k] && n < 20) begin
      if (busy[k]) nb++;
      oe[k] = 1'($urandom); we[k] = 1'($urandom);
      addr[k] = 16'($urandom_range(0, 31)); din[k] = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    oe[k] = 1'b0; we[k] = 1'b0;
    if (busy[k]) nb++;
    check($sformatf("d%0d_latency_%0h", k, a), n, ws(k) + 1);
    check($sformatf("d%0d_busy_cycles_%0h", k, a), nb, ws(k) + 1);
    if (wr) begin
      if (a >= 16'hF000) m_wp[k] = 1'b1;
      else mdl[key] = d;
    end else begin
      m_dknown[k] = mdl.exists(key);
      if (m_dknown[k]) m_dout[k] = mdl[key];
    end
    if (m_dknown[k]) check($sformatf("d%0d_rdata_%0h", k, a), dout[k], m_dout[k]);
    check($sformatf("d%0d_wp_err", k), wp[k], m_wp[k]);
    @(posedge clk); #1;
    check($sformatf("d%0d_ready_pulse", k), rdy[k], 0);
    check($sformatf("d%0d_back_idle", k), busy[k], 0);
  endtask

  initial begin
    bit [15:0] a;
    int kr;
    bit wr;
    for (int k = 0; k < 2; k++) begin
      oe[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; din[k] = '0;
    end
    u_ws0.r_mem[16'hFFFE] = 8'h10;
    u_ws0.r_mem[16'hFFFF] = 8'hC3;
    u_ws3.r_mem[16'hFFFE] = 8'h10;
    u_ws3.r_mem[16'hFFFF] = 8'hC3;
    for (int k = 0; k < 2; k++) begin
      mdl[{k[0], 16'hFFFE}] = 8'h10;
      mdl[{k[0], 16'hFFFF}] = 8'hC3;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    access(0, 1'b1, 16'h1000, 8'h12);
    access(0, 1'b0, 16'h1000, 8'h00);
    access(1, 1'b1, 16'h0010, 8'h5A);
    access(1, 1'b0, 16'h0010, 8'h00);

    for (int k = 0; k < 2; k++) begin
      access(k, 1'b1, 16'hFFFE, 8'h77);
      access(k, 1'b0, 16'hFFFE, 8'h00);
    end

    access(0, 1'b0, 16'hFFFF, 8'h00);
    access(0, 1'b1, 16'h0000, 8'h01);

    for (int k = 0; k < 2; k++) begin
      access(k, 1'b1, 16'h0100, 8'h3C);
      @(negedge clk);
      oe[k] = 1'b1; we[k] = 1'b1; addr[k] = 16'h0100; din[k] = 8'hFF;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check($sformatf("d%0d_both_busy", k), busy[k], 0);
        check($sformatf("d%0d_both_ready", k), rdy[k], 0);
      end
      oe[k] = 1'b0; we[k] = 1'b0;
      access(k, 1'b0, 16'h0100, 8'h00);
    end

    for (int i = 0; i < 60; i++) begin
      kr = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 3) == 0 ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                    : 16'($urandom_range(0, 31));
      access(kr, wr, a, 8'($urandom));
    end

    access(1, 1'b1, 16'h0200, 8'hA5);
    @(negedge clk);
    addr[1] = 16'h0200; din[1] = 8'h33; we[1] = 1'b1;
    @(posedge clk); #1;
    we[1] = 1'b0;
    check("rst_wait_entered", busy[1], 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_idle_outputs("rst_in_wait");
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("rst_hold_ready", rdy[1], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 1'b0, 16'h0200, 8'h00);
    check("rst_abort_data", dout[1], 8'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
